// File: rtl/demux1_l1_rx.sv
// RX-side 1:2 lane demultiplexer: splits a byte-interleaved clk_2f stream into
// an aligned lane 0 / lane 1 pair, recovering lane phase from valid_in.
module demux1_l1_rx #(
  parameter int unsigned IDLE_PAIRS = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_0,
  output logic [DATA_W-1:0] data_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic              pair_strobe,
  output logic              aligned
);

  localparam int unsigned CNT_W = $clog2(IDLE_PAIRS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LANE1 = 2'd1,
    LANE0 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]    idle_cnt_inc;
  logic [DATA_W-1:0]   hold0_q, hold0_d;
  logic                hv0_q, hv0_d;
  logic [DATA_W-1:0]   data_0_q, data_0_d;
  logic [DATA_W-1:0]   data_1_q, data_1_d;
  logic                valid_0_q, valid_0_d;
  logic                valid_1_q, valid_1_d;
  logic                pair_strobe_q, pair_strobe_d;
  logic                aligned_q, aligned_d;

  // Saturating increment of the all-invalid pair counter
  assign idle_cnt_inc = (idle_cnt_q == CNT_W'(IDLE_PAIRS)) ? idle_cnt_q
                                                           : idle_cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    hold0_d       = hold0_q;
    hv0_d         = hv0_q;
    data_0_d      = data_0_q;
    data_1_d      = data_1_q;
    valid_0_d     = valid_0_q;
    valid_1_d     = valid_1_q;
    pair_strobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          hold0_d = data_in;
          hv0_d   = 1'b1;
          state_d = LANE1;
        end
      end
      LANE1: begin
        data_0_d      = hv0_q ? hold0_q : DATA_W'(0);
        valid_0_d     = hv0_q;
        data_1_d      = valid_in ? data_in : DATA_W'(0);
        valid_1_d     = valid_in;
        pair_strobe_d = 1'b1;
        state_d       = LANE0;
        // A run of IDLE_PAIRS all-invalid pairs drops the lane lock
        if (!hv0_q && !valid_in) begin
          idle_cnt_d = idle_cnt_inc;
          if (idle_cnt_inc == CNT_W'(IDLE_PAIRS)) begin
            state_d    = IDLE;
            idle_cnt_d = '0;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      LANE0: begin
        hold0_d = data_in;
        hv0_d   = valid_in;
        state_d = LANE1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    aligned_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= IDLE;
      idle_cnt_q    <= '0;
      hold0_q       <= '0;
      hv0_q         <= 1'b0;
      data_0_q      <= '0;
      data_1_q      <= '0;
      valid_0_q     <= 1'b0;
      valid_1_q     <= 1'b0;
      pair_strobe_q <= 1'b0;
      aligned_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      hold0_q       <= hold0_d;
      hv0_q         <= hv0_d;
      data_0_q      <= data_0_d;
      data_1_q      <= data_1_d;
      valid_0_q     <= valid_0_d;
      valid_1_q     <= valid_1_d;
      pair_strobe_q <= pair_strobe_d;
      aligned_q     <= aligned_d;
    end
  end

  assign data_0      = data_0_q;
  assign data_1      = data_1_q;
  assign valid_0     = valid_0_q;
  assign valid_1     = valid_1_q;
  assign pair_strobe = pair_strobe_q;
  assign aligned     = aligned_q;

endmodule

// File: tb/tb_demux1_l1_rx.sv
// Self-checking bench for demux1_l1_rx: directed scenarios plus randomized
// traffic compared against a queue-based lane-pairing model.
module tb_demux1_l1_rx;

  localparam int unsigned IDLE_PAIRS = 4;
  localparam int unsigned DATA_W     = 8;

  logic              clk_2f;
  logic              reset_L;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic              valid_0;
  logic              valid_1;
  logic              pair_strobe;
  logic              aligned;

  demux1_l1_rx #(
    .IDLE_PAIRS(IDLE_PAIRS),
    .DATA_W    (DATA_W)
  ) dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_0     (data_0),
    .data_1     (data_1),
    .valid_0    (valid_0),
    .valid_1    (valid_1),
    .pair_strobe(pair_strobe),
    .aligned    (aligned)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes after lock are grouped in twos; a pending queue
  // holds the lane 0 half until its partner arrives.
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              v;
  } lane_byte_t;

  lane_byte_t        pend[$];
  bit                m_locked;
  int                m_run;
  logic [DATA_W-1:0] m_d0, m_d1;
  bit                m_v0, m_v1, m_strobe;

  task automatic model_reset();
    pend.delete();
    m_locked = 0;
    m_run    = 0;
    m_d0     = '0;
    m_d1     = '0;
    m_v0     = 0;
    m_v1     = 0;
    m_strobe = 0;
  endtask

  task automatic model_edge(input logic [DATA_W-1:0] d, input logic v);
    lane_byte_t b, l0;
    b.d = d;
    b.v = v;
    m_strobe = 0;
    if (!m_locked) begin
      if (v) begin
        m_locked = 1;
        pend.push_back(b);
      end
    end else if (pend.size() == 0) begin
      pend.push_back(b);
    end else begin
      l0       = pend.pop_front();
      m_v0     = l0.v;
      m_d0     = l0.v ? l0.d : '0;
      m_v1     = v;
      m_d1     = v ? d : '0;
      m_strobe = 1;
      m_run    = (!l0.v && !v) ? m_run + 1 : 0;
      if (m_run >= int'(IDLE_PAIRS)) begin
        m_locked = 0;
        m_run    = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_0"},  32'(data_0),      32'(m_d0));
    chk({tag, ".data_1"},  32'(data_1),      32'(m_d1));
    chk({tag, ".valid_0"}, 32'(valid_0),     32'(m_v0));
    chk({tag, ".valid_1"}, 32'(valid_1),     32'(m_v1));
    chk({tag, ".strobe"},  32'(pair_strobe), 32'(m_strobe));
    chk({tag, ".aligned"}, 32'(aligned),     32'(m_locked));
  endtask

  // Present one byte for one clk_2f edge, then check all outputs.
  task automatic step(input logic [DATA_W-1:0] d, input logic v, input string tag);
    data_in  = d;
    valid_in = v;
    @(posedge clk_2f);
    model_edge(d, v);
    #1;
    check_all(tag);
  endtask

  int dens;

  initial begin
    model_reset();
    reset_L  = 1'b0;
    data_in  = 8'hFF;
    valid_in = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk_2f);
      #1;
      check_all("reset");
    end
    reset_L = 1'b1;

    // Basic pair
    step(8'hA5, 1'b1, "bp0");
    step(8'h3C, 1'b1, "bp1");
    chk("bp_d0", 32'(data_0), 32'h0000_00A5);
    chk("bp_d1", 32'(data_1), 32'h0000_003C);
    chk("bp_strobe", 32'(pair_strobe), 32'd1);
    step(8'h00, 1'b0, "bp_hold");
    chk("bp_strobe_once", 32'(pair_strobe), 32'd0);

    // Async reset between lane 0 and lane 1 bytes
    step(8'h11, 1'b1, "mid0");
    #3;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst_d0", 32'(data_0), 32'd0);
    #1;
    reset_L = 1'b1;
    step(8'h22, 1'b1, "re0");
    chk("re0_nostrobe", 32'(pair_strobe), 32'd0);
    step(8'h33, 1'b1, "re1");
    chk("re1_d0", 32'(data_0), 32'h0000_0022);

    // Continuous stream 01..08
    for (int i = 1; i <= 8; i++) step(DATA_W'(i), 1'b1, "stream");
    chk("stream_d0", 32'(data_0), 32'h0000_0007);
    chk("stream_d1", 32'(data_1), 32'h0000_0008);

    // Invalid lane 0 byte forced to zero, phase kept
    step(8'h77, 1'b0, "inv0");
    step(8'h12, 1'b1, "inv1");
    chk("inv_d0", 32'(data_0), 32'd0);
    chk("inv_v0", 32'(valid_0), 32'd0);
    chk("inv_d1", 32'(data_1), 32'h0000_0012);
    step(8'h9A, 1'b1, "inv2");
    step(8'hBC, 1'b1, "inv3");
    chk("inv_phase", 32'(data_0), 32'h0000_009A);

    // Alignment loss after IDLE_PAIRS all-invalid pairs
    for (int i = 0; i < 8; i++) step(8'hEE, 1'b0, "loss");
    chk("loss_aligned", 32'(aligned), 32'd0);
    step(8'h44, 1'b0, "loss_idle");
    step(8'h55, 1'b1, "relock0");
    step(8'h66, 1'b1, "relock1");
    chk("relock_d0", 32'(data_0), 32'h0000_0055);

    // Misaligned start: lone valid byte then idle line
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0, "drain");
    step(8'hC3, 1'b1, "mis0");
    step(8'h00, 1'b0, "mis1");
    chk("mis_d0", 32'(data_0), 32'h0000_00C3);
    chk("mis_v1", 32'(valid_1), 32'd0);
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0, "mis_run");
    chk("mis_still_aligned", 32'(aligned), 32'd1);
    step(8'h00, 1'b0, "mis_last0");
    step(8'h00, 1'b0, "mis_last1");
    chk("mis_unaligned", 32'(aligned), 32'd0);

    // Randomized traffic with varying valid density
    dens = 90;
    for (int i = 0; i < 900; i++) begin
      if (i % 60 == 0) begin
        case ($urandom_range(2))
          0:       dens = 90;
          1:       dens = 50;
          default: dens = 4;
        endcase
      end
      step(DATA_W'($urandom), ($urandom_range(99) < dens), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
